demux_1x8_stream: RTL and testbench
===================================

// Module: demux_1x8_stream
// PURPOSE
//   Inverse of the 8:1 select mux: steers one N-bit input stream to one of
//   eight output channels. Uses valid/ready handshakes on both sides.
//   Each channel holds a one-entry output register. The destination is taken
//   from select input s, or from an internal round-robin pointer.
//   Sits between a single producer and eight independent consumers.
// PARAMETERS
//   N  3  data width of din and of each channel output y0..y7
// PORTS
//   clk        input   1      system clock, all state updates on rising edge
//   reset_n    input   1      asynchronous active-low reset
//   din        input   N      input data word
//   s          input   3      destination channel when rr_en=0
//   rr_en      input   1      1: destination = internal pointer ptr; 0: destination = s
//   in_valid   input   1      producer has a word on din
//   in_ready   output  1      block accepts din this cycle (combinational)
//   y0..y7     output  N each channel data registers
//   out_valid  output  8      bit i: channel i register holds an unconsumed word
//   out_ready  input   8      bit i: consumer i takes y_i this cycle
//   ptr        output  3      current round-robin pointer (status)
// BEHAVIOUR
//   - Reset (reset_n=0, async): y0..y7=0, out_valid=0, ptr=0. Takes effect
//     immediately, mid-transfer included. In-flight words are discarded.
//   - dest = rr_en ? ptr : s. This is combinational; a change to rr_en takes
//     effect the same cycle.
//   - in_ready = ~out_valid[dest] | out_ready[dest].
//     A full channel can accept in the same cycle it drains.
//   - Accept = in_valid & in_ready.
//     On accept: y_dest <= din, out_valid[dest] <= 1. Latency is 1 cycle,
//     din to y_dest/out_valid.
//   - Drain of channel i = out_valid[i] & out_ready[i].
//     Drain with no fill that cycle: out_valid[i] <= 0 and y_i is unchanged.
//     Drain plus fill in the same cycle: out_valid[i] stays 1 and y_i takes
//     the new word.
//   - y_i holds its last value while not loaded. The value is only
//     meaningful while out_valid[i]=1.
//   - Round robin: ptr <= ptr+1 mod 8 on each accept while rr_en=1.
//     ptr wraps 7->0.
//   - The pointer never skips a full channel. While channel ptr is full and
//     not draining, in_ready=0 and ptr holds.
//   - ptr is unchanged on any cycle with rr_en=0, and on any cycle with no
//     accept.
//   - Producer rule: din, s and rr_en stay stable while in_valid=1 and
//     in_ready=0. in_valid must not drop before accept.
//   - Channels drain independently of each other and of the input side.
//     Up to 8 drains and 1 fill can happen per cycle.
//   - out_ready[i] while out_valid[i]=0 has no effect.
// TESTING
//   1 Reset: hold reset_n=0 -> y0..y7=0, out_valid=8'h00, ptr=0,
//     in_ready=1 for any s.
//   2 Directed fill: rr_en=0, s=5, din=3'b101, out_ready=0, one accept
//     -> next cycle out_valid=8'h20, y5=3'b101.
//     Second word to s=5 -> in_ready=0 (stall).
//   3 Fill on drain: continue test 2 with out_ready[5]=1, din=3'b010
//     -> accepted that cycle. Next cycle out_valid[5]=1, y5=3'b010.
//   4 Round robin wrap: rr_en=1, out_ready=8'hFF, send 9 words 1..9
//     -> land on ch0..7 then ch0 (y0=1 then 1+8 mod 2^N). ptr ends at 1.
//   5 RR stall: rr_en=1, ch3 full, out_ready[3]=0, ptr=3 -> in_ready=0 and
//     ptr stays 3 for 4 cycles. Raise out_ready[3] -> accept, ptr->4.
//   6 Reset mid-operation: out_valid=8'hFF, ptr=6, pull reset_n low
//     asynchronously mid-cycle -> all outputs clear immediately without a
//     clock edge.

Source files
------------

// File: rtl/demux_1x8_stream.sv
// 1-to-8 stream demultiplexer with valid/ready handshakes on both sides.
// Each output channel is a one-entry register; the destination comes from s or a round-robin pointer.
module demux_1x8_stream #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] din,
    input  logic [2:0]   s,
    input  logic         rr_en,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] y0,
    output logic [N-1:0] y1,
    output logic [N-1:0] y2,
    output logic [N-1:0] y3,
    output logic [N-1:0] y4,
    output logic [N-1:0] y5,
    output logic [N-1:0] y6,
    output logic [N-1:0] y7,
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ready,
    output logic [2:0]   ptr
);

    localparam int unsigned NumCh = 8;

    logic [N-1:0] data_q [NumCh];
    logic [7:0]   valid_q, valid_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   dest;
    logic         accept;
    logic [7:0]   fill;
    logic [7:0]   drain;

    always_comb begin
        dest     = rr_en ? ptr_q : s;
        // A full channel still accepts when its consumer drains it this cycle.
        in_ready = ~valid_q[dest] | out_ready[dest];
        accept   = in_valid & in_ready;
        fill     = '0;
        drain    = '0;
        valid_d  = '0;
        for (int i = 0; i < NumCh; i++) begin
            fill[i]    = accept && (dest == 3'(i));
            drain[i]   = valid_q[i] & out_ready[i];
            valid_d[i] = fill[i] | (valid_q[i] & ~drain[i]);
        end
        ptr_d = (accept && rr_en) ? ptr_q + 3'd1 : ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < NumCh; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < NumCh; i++) begin
                if (fill[i]) begin
                    data_q[i] <= din;
                end
            end
        end
    end

    assign y0        = data_q[0];
    assign y1        = data_q[1];
    assign y2        = data_q[2];
    assign y3        = data_q[3];
    assign y4        = data_q[4];
    assign y5        = data_q[5];
    assign y6        = data_q[6];
    assign y7        = data_q[7];
    assign out_valid = valid_q;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_demux_1x8_stream.sv
// Bench for demux_1x8_stream: directed vector table, reset corner cases and
// randomized traffic checked against a per-channel occupancy model.
module tb_demux_1x8_stream;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] din;
    logic [2:0]   s;
    logic         rr_en;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [2:0]   ptr;
    logic [N-1:0] yv [8];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: occupancy flag and held word per channel, plus pointer.
    bit           m_full [8];
    logic [N-1:0] m_data [8];
    int           m_ptr;

    demux_1x8_stream #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .s         (s),
        .rr_en     (rr_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .y5        (y5),
        .y6        (y6),
        .y7        (y7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;
    assign yv[4] = y4;
    assign yv[5] = y5;
    assign yv[6] = y6;
    assign yv[7] = y7;

    typedef struct {
        logic       iv;
        logic [2:0] din;
        logic [2:0] s;
        logic       rr;
        logic [7:0] ordy;
        logic       e_rdy;
        logic [7:0] e_ov;
        logic [2:0] e_ptr;
        logic [2:0] ych;
        logic [2:0] e_y;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
        end
        m_ptr = 0;
    endtask

    function automatic int m_dest();
        return rr_en ? m_ptr : int'(s);
    endfunction

    function automatic bit m_ready();
        int d = m_dest();
        return !m_full[d] || out_ready[d];
    endfunction

    function automatic logic [7:0] m_ov();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    // Compare every DUT output with the model; call with inputs already applied.
    task automatic check_model(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov()));
        chk({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
        for (int i = 0; i < 8; i++) begin
            if (yv[i] !== m_data[i]) chk($sformatf("%s.y%0d", tag, i), 32'(yv[i]), 32'(m_data[i]));
        end
    endtask

    // Clock the DUT once and apply the same transfer rules to the model.
    task automatic advance();
        bit acc = in_valid && m_ready();
        int d   = m_dest();
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
        end
        if (acc) begin
            m_full[d] = 1'b1;
            m_data[d] = din;
            if (rr_en) m_ptr = (m_ptr + 1) % 8;
        end
        @(negedge clk);
    endtask

    task automatic apply(input logic iv, input logic [2:0] d, input logic [2:0] sel,
                         input logic rr, input logic [7:0] ordy);
        in_valid  = iv;
        din       = d;
        s         = sel;
        rr_en     = rr;
        out_ready = ordy;
        #1;
    endtask

    initial begin
        bit       pend;
        int       cyc;

        reset_n = 1'b0;
        apply(1'b0, 3'd0, 3'd0, 1'b0, 8'h00);
        model_reset();
        @(negedge clk);

        // Reset state, in_ready for every select value.
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 3'd0, 3'(i), 1'b0, 8'h00);
            chk($sformatf("reset.in_ready_s%0d", i), 32'(in_ready), 32'd1);
        end
        chk("reset.out_valid", 32'(out_valid), 32'h00);
        chk("reset.ptr", 32'(ptr), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("reset.y%0d", i), 32'(yv[i]), 32'd0);
        reset_n = 1'b1;

        // Directed fill, stall, fill-on-drain, round-robin wrap, RR stall.
        tbl[0]  = '{1'b1, 3'd5, 3'd5, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 3'd0, 3'd0};
        tbl[1]  = '{1'b1, 3'd2, 3'd5, 1'b0, 8'h00, 1'b0, 8'h20, 3'd0, 3'd5, 3'd5};
        tbl[2]  = '{1'b1, 3'd2, 3'd5, 1'b0, 8'h20, 1'b1, 8'h20, 3'd0, 3'd5, 3'd5};
        tbl[3]  = '{1'b0, 3'd0, 3'd5, 1'b0, 8'h00, 1'b0, 8'h20, 3'd0, 3'd5, 3'd2};
        tbl[4]  = '{1'b0, 3'd0, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h20, 3'd0, 3'd5, 3'd2};
        tbl[5]  = '{1'b1, 3'd1, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 3'd5, 3'd2};
        tbl[6]  = '{1'b1, 3'd2, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h01, 3'd1, 3'd0, 3'd1};
        tbl[7]  = '{1'b1, 3'd3, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h02, 3'd2, 3'd1, 3'd2};
        tbl[8]  = '{1'b1, 3'd4, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h04, 3'd3, 3'd2, 3'd3};
        tbl[9]  = '{1'b1, 3'd5, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h08, 3'd4, 3'd3, 3'd4};
        tbl[10] = '{1'b1, 3'd6, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h10, 3'd5, 3'd4, 3'd5};
        tbl[11] = '{1'b1, 3'd7, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h20, 3'd6, 3'd5, 3'd6};
        tbl[12] = '{1'b1, 3'd0, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h40, 3'd7, 3'd6, 3'd7};
        tbl[13] = '{1'b1, 3'd1, 3'd0, 1'b1, 8'hFF, 1'b1, 8'h80, 3'd0, 3'd7, 3'd0};
        tbl[14] = '{1'b0, 3'd0, 3'd1, 1'b0, 8'h00, 1'b1, 8'h01, 3'd1, 3'd0, 3'd1};
        tbl[15] = '{1'b1, 3'd6, 3'd3, 1'b0, 8'h00, 1'b1, 8'h01, 3'd1, 3'd0, 3'd1};
        tbl[16] = '{1'b1, 3'd3, 3'd0, 1'b1, 8'h00, 1'b1, 8'h09, 3'd1, 3'd3, 3'd6};
        tbl[17] = '{1'b1, 3'd4, 3'd0, 1'b1, 8'h00, 1'b1, 8'h0B, 3'd2, 3'd1, 3'd3};
        for (int i = 18; i < 22; i++) begin
            tbl[i] = '{1'b1, 3'd7, 3'd0, 1'b1, 8'h00, 1'b0, 8'h0F, 3'd3, 3'd2, 3'd4};
        end
        tbl[22] = '{1'b1, 3'd7, 3'd0, 1'b1, 8'h08, 1'b1, 8'h0F, 3'd3, 3'd3, 3'd6};
        tbl[23] = '{0, 3'd0, 3'd0, 1'b1, 8'h00, 1'b1, 8'h0F, 3'd4, 3'd3, 3'd7};

        for (int r = 0; r < 24; r++) begin
            apply(tbl[r].iv, tbl[r].din, tbl[r].s, tbl[r].rr, tbl[r].ordy);
            chk($sformatf("vec%0d.in_ready", r), 32'(in_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("vec%0d.out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
            chk($sformatf("vec%0d.ptr", r), 32'(ptr), 32'(tbl[r].e_ptr));
            chk($sformatf("vec%0d.y%0d", r, tbl[r].ych), 32'(yv[tbl[r].ych]), 32'(tbl[r].e_y));
            check_model($sformatf("vec%0d", r));
            advance();
        end

        // Fill all channels with ptr left at 6, then reset asynchronously mid-cycle.
        reset_n = 1'b0;
        #1;
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 3'(i + 1), 3'd0, 1'b1, 8'h00);
            check_model($sformatf("full_rr%0d", i));
            advance();
        end
        for (int i = 6; i < 8; i++) begin
            apply(1'b1, 3'(i + 1), 3'(i), 1'b0, 8'h00);
            check_model($sformatf("full_sel%0d", i));
            advance();
        end
        apply(1'b0, 3'd0, 3'd0, 1'b0, 8'h00);
        chk("full.out_valid", 32'(out_valid), 32'hFF);
        chk("full.ptr", 32'(ptr), 32'd6);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'h00);
        chk("async_rst.ptr", 32'(ptr), 32'd0);
        chk("async_rst.y6", 32'(y6), 32'd0);
        chk("async_rst.y0", 32'(y0), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic; producer holds its word stable until accepted.
        pend = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            logic [7:0] ordy;
            ordy = 8'($urandom) & 8'($urandom);
            if (pend) begin
                apply(1'b1, din, s, rr_en, ordy);
            end else begin
                apply(($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
                      ($urandom_range(0, 1) == 1), ordy);
            end
            check_model($sformatf("rand%0d", cyc));
            pend = in_valid && !m_ready();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
